// File: rtl/s2h_gate_pkg.sv
// -----------------------------------------------------------------------------
// s2h_gate_pkg
// Shared types and helpers for the S2MM command-ordered stream gate.
//   gate_state_t : gate FSM state (IDLE = no outstanding command, OPEN = a
//                  tag sits at the FIFO head and its channel is routed).
//   ch_idx()     : channel tag width for a given channel count, at least 1.
//   DROP_CNT_W   : width of the discarded-beat counter.
// -----------------------------------------------------------------------------
package s2h_gate_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OPEN = 1'b1
  } gate_state_t;

  localparam int DROP_CNT_W = 16;

  // Tag width: clog2 of the channel count, but never narrower than one bit.
  function automatic int ch_idx(input int num_ch);
    int w;
    w = $clog2(num_ch);
    if (w < 1) begin
      return 1;
    end else begin
      return w;
    end
  endfunction

endpackage

// File: rtl/s2h_tag_fifo.sv
// -----------------------------------------------------------------------------
// s2h_tag_fifo
// Synchronous FIFO of channel tags, one entry per outstanding S2MM command.
// The head entry is presented combinationally from the read pointer, so a
// pushed tag is visible at the head the cycle after the push.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (clears pointers/count)
//   push       : write push_data (ignored while full)
//   push_data  : tag to store
//   pop        : retire the head entry (ignored while empty)
//   head       : tag at the read pointer
//   count      : number of stored tags, 0 .. 2^DEPTH_LOG2
//   full       : count equals 2^DEPTH_LOG2
// -----------------------------------------------------------------------------
module s2h_tag_fifo #(
  parameter int W          = 1,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [W-1:0]          push_data,
  input  logic                  pop,
  output logic [W-1:0]          head,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [W-1:0]          mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  assign full      = (count_r == FULL_CNT);
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & (count_r != {(DEPTH_LOG2+1){1'b0}});
  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage, pointers and occupancy; pointers wrap naturally at 2^DEPTH_LOG2.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {DEPTH_LOG2{1'b0}};
      rd_ptr_r <= {DEPTH_LOG2{1'b0}};
      count_r  <= {(DEPTH_LOG2+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + DEPTH_LOG2'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + DEPTH_LOG2'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (DEPTH_LOG2+1)'(1);
        2'b01:   count_r <= count_r - (DEPTH_LOG2+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/s2h_stream_gate.sv
// -----------------------------------------------------------------------------
// s2h_stream_gate
// Command-ordered gate/mux between NUM_CH source streams and the single S2MM
// data input of an AXI datamover. Each accepted S2MM command pushes its channel
// tag into a tag FIFO; the gate then forwards exactly one packet (ending on
// tlast) from the channel at the FIFO head, pops, and moves to the next tag.
//
// Optional feature macro: S2H_STREAM_GATE_DRAIN_EN
//   defined     : while no command is outstanding every source is accepted and
//                 its beats are discarded, counted in drop_count (saturating).
//   not defined : stray beats stall while idle; drop_count is constant 0.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   s_cmd_*                     command from the control master (+ channel tag)
//   m_cmd_*                     command to the datamover (payload passed through)
//   s_tdata/s_tvalid/s_tlast/s_tready  per-channel source streams
//   m_tdata/m_tvalid/m_tlast/m_tready  datamover S2MM stream
//   pending                     outstanding command count
//   pkt_done, pkt_done_ch       one-cycle pulse and channel of a finished packet
//   drop_count                  discarded-beat counter
// -----------------------------------------------------------------------------
module s2h_stream_gate
  import s2h_gate_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 64,
  parameter int CMD_W      = 72,
  parameter int DEPTH_LOG2 = 3,
  localparam int CH_W      = ch_idx(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_cmd_tvalid,
  output logic                     s_cmd_tready,
  input  logic [CMD_W-1:0]         s_cmd_tdata,
  input  logic [CH_W-1:0]          s_cmd_ch,
  output logic                     m_cmd_tvalid,
  input  logic                     m_cmd_tready,
  output logic [CMD_W-1:0]         m_cmd_tdata,
  input  logic [NUM_CH*DATA_W-1:0] s_tdata,
  input  logic [NUM_CH-1:0]        s_tvalid,
  input  logic [NUM_CH-1:0]        s_tlast,
  output logic [NUM_CH-1:0]        s_tready,
  output logic [DATA_W-1:0]        m_tdata,
  output logic                     m_tvalid,
  output logic                     m_tlast,
  input  logic                     m_tready,
  output logic [DEPTH_LOG2:0]      pending,
  output logic                     pkt_done,
  output logic [CH_W-1:0]          pkt_done_ch,
  output logic [DROP_CNT_W-1:0]    drop_count
);

  localparam logic [DEPTH_LOG2:0] ONE_CNT = {{DEPTH_LOG2{1'b0}}, 1'b1};

  gate_state_t         state_r;
  gate_state_t         state_nxt_s;
  logic [CH_W-1:0]     head_s;
  logic [DEPTH_LOG2:0] count_s;
  logic                full_s;
  logic                cmd_fire_s;
  logic                data_fire_s;
  logic                pkt_done_r;
  logic [CH_W-1:0]     pkt_done_ch_r;

  // Command path: the datamover only sees a command when a tag slot is free.
  assign m_cmd_tvalid = s_cmd_tvalid & ~full_s;
  assign s_cmd_tready = m_cmd_tready & ~full_s;
  assign m_cmd_tdata  = s_cmd_tdata;
  assign cmd_fire_s   = m_cmd_tvalid & m_cmd_tready;

  s2h_tag_fifo #(
    .W          (CH_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_fire_s),
    .push_data (s_cmd_ch),
    .pop       (data_fire_s),
    .head      (head_s),
    .count     (count_s),
    .full      (full_s)
  );

  assign pending = count_s;

  // Gate state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Data mux, per-channel ready, packet-end detection and next gate state.
  // A head tag outside 0..NUM_CH-1 matches no channel, so the gate stalls.
  always_comb begin
    m_tdata     = {DATA_W{1'b0}};
    m_tvalid    = 1'b0;
    m_tlast     = 1'b0;
    s_tready    = {NUM_CH{1'b0}};
    state_nxt_s = state_r;
    case (state_r)
      OPEN: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (head_s == CH_W'(i)) begin
            m_tdata     = s_tdata[i*DATA_W +: DATA_W];
            m_tvalid    = s_tvalid[i];
            m_tlast     = s_tlast[i];
            s_tready[i] = m_tready;
          end else begin
            s_tready[i] = 1'b0;
          end
        end
      end
      IDLE: begin
`ifdef S2H_STREAM_GATE_DRAIN_EN
        s_tready = {NUM_CH{1'b1}};
`else
        s_tready = {NUM_CH{1'b0}};
`endif
      end
      default: begin
        s_tready = {NUM_CH{1'b0}};
      end
    endcase

    data_fire_s = m_tvalid & m_tready & m_tlast;

    // Open while at least one tag will remain after this cycle's push/pop.
    case (state_r)
      IDLE: begin
        if (cmd_fire_s) begin
          state_nxt_s = OPEN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      OPEN: begin
        if (data_fire_s && !cmd_fire_s && (count_s == ONE_CNT)) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = OPEN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Packet completion pulse; the channel is held between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_done_r    <= 1'b0;
      pkt_done_ch_r <= {CH_W{1'b0}};
    end else begin
      pkt_done_r <= data_fire_s;
      if (data_fire_s) begin
        pkt_done_ch_r <= head_s;
      end else begin
        pkt_done_ch_r <= pkt_done_ch_r;
      end
    end
  end

  assign pkt_done    = pkt_done_r;
  assign pkt_done_ch = pkt_done_ch_r;

`ifdef S2H_STREAM_GATE_DRAIN_EN
  logic [DROP_CNT_W-1:0] drop_cnt_r;
  logic [4:0]            drop_beats_s;
  logic [DROP_CNT_W:0]   drop_sum_s;

  // Number of beats discarded this cycle (all sources are accepted in IDLE).
  always_comb begin
    drop_beats_s = 5'd0;
    if (state_r == IDLE) begin
      for (int i = 0; i < NUM_CH; i++) begin
        drop_beats_s = drop_beats_s + {4'd0, s_tvalid[i]};
      end
    end else begin
      drop_beats_s = 5'd0;
    end
    drop_sum_s = {1'b0, drop_cnt_r} + {{(DROP_CNT_W-4){1'b0}}, drop_beats_s};
  end

  // Saturating discarded-beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_r <= {DROP_CNT_W{1'b0}};
    end else if (drop_sum_s[DROP_CNT_W]) begin
      drop_cnt_r <= {DROP_CNT_W{1'b1}};
    end else begin
      drop_cnt_r <= drop_sum_s[DROP_CNT_W-1:0];
    end
  end

  assign drop_count = drop_cnt_r;
`else
  assign drop_count = {DROP_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_s2h_stream_gate.sv
module tb_s2h_stream_gate;

  localparam int NUM_CH = 2;
  localparam int DW     = 64;
  localparam int CW     = 72;
  localparam int DL2    = 3;
  localparam int CHW    = 1;

  typedef struct packed {
    logic [3:0]  ch;
    logic        last;
    logic [63:0] data;
  } beat_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 s_cmd_tvalid;
  logic                 s_cmd_tready;
  logic [CW-1:0]        s_cmd_tdata;
  logic [CHW-1:0]       s_cmd_ch;
  logic                 m_cmd_tvalid;
  logic                 m_cmd_tready;
  logic [CW-1:0]        m_cmd_tdata;
  logic [NUM_CH*DW-1:0] s_tdata;
  logic [NUM_CH-1:0]    s_tvalid;
  logic [NUM_CH-1:0]    s_tlast;
  logic [NUM_CH-1:0]    s_tready;
  logic [DW-1:0]        m_tdata;
  logic                 m_tvalid;
  logic                 m_tlast;
  logic                 m_tready;
  logic [DL2:0]         pending;
  logic                 pkt_done;
  logic [CHW-1:0]       pkt_done_ch;
  logic [15:0]          drop_count;

  always #5 clk = ~clk;

  s2h_stream_gate #(
    .NUM_CH(NUM_CH), .DATA_W(DW), .CMD_W(CW), .DEPTH_LOG2(DL2)
  ) dut (
    .clk(clk), .rst(rst),
    .s_cmd_tvalid(s_cmd_tvalid), .s_cmd_tready(s_cmd_tready),
    .s_cmd_tdata(s_cmd_tdata), .s_cmd_ch(s_cmd_ch),
    .m_cmd_tvalid(m_cmd_tvalid), .m_cmd_tready(m_cmd_tready), .m_cmd_tdata(m_cmd_tdata),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .pending(pending), .pkt_done(pkt_done), .pkt_done_ch(pkt_done_ch),
    .drop_count(drop_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Source packet queues, expected datamover stream, and the outstanding tags.
  beat_t src_q [NUM_CH][$];
  beat_t exp_q[$];
  int    tag_q[$];

  // Observations taken mid-cycle (negedge).
  logic              o_rst, o_mvalid, o_mfire, o_last, o_cmd_fire, o_cmd_ready, o_mcv, o_done;
  logic [63:0]       o_data;
  logic [NUM_CH-1:0] o_sfire, o_sready;
  logic [DL2:0]      o_pending;
  logic [CHW-1:0]    o_done_ch;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic mk_pkt(input int ch, input int len, input bit to_exp);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.ch   = 4'(ch);
      b.last = (k == len - 1);
      b.data = {$urandom, $urandom};
      src_q[ch].push_back(b);
      if (to_exp) exp_q.push_back(b);
    end
  endtask

  // Present the head beat of each source; once valid it is held until taken.
  task automatic drive_src(input int gap_pct);
    for (int i = 0; i < NUM_CH; i++) begin
      if (src_q[i].size() == 0) begin
        s_tvalid[i] = 1'b0;
        s_tlast[i]  = 1'b0;
        s_tdata[i*DW +: DW] = '0;
      end else begin
        if (!s_tvalid[i]) s_tvalid[i] = ($urandom_range(99) >= gap_pct);
        s_tdata[i*DW +: DW] = src_q[i][0].data;
        s_tlast[i] = src_q[i][0].last;
      end
    end
  endtask

  // One clock: sample at negedge, then apply handshakes after the posedge.
  task automatic cycle();
    @(negedge clk);
    o_rst       = rst;
    o_mvalid    = m_tvalid;
    o_mfire     = m_tvalid & m_tready;
    o_last      = m_tlast;
    o_data      = m_tdata;
    o_sfire     = s_tvalid & s_tready;
    o_sready    = s_tready;
    o_cmd_fire  = s_cmd_tvalid & s_cmd_tready;
    o_cmd_ready = s_cmd_tready;
    o_mcv       = m_cmd_tvalid;
    o_pending   = pending;
    o_done      = pkt_done;
    o_done_ch   = pkt_done_ch;
    @(posedge clk);
    #1;
    if (o_cmd_fire) tag_q.push_back(int'(s_cmd_ch));
    if (o_mfire && o_last && tag_q.size() > 0) void'(tag_q.pop_front());
    for (int i = 0; i < NUM_CH; i++) begin
      if (o_sfire[i]) begin
        void'(src_q[i].pop_front());
        s_tvalid[i] = 1'b0;
      end
    end
    if (o_rst) tag_q.delete();
  endtask

  // Feed one single-beat packet per outstanding tag and wait for the FIFO to empty.
  task automatic drain_fifo();
    int c;
    s_cmd_tvalid = 1'b0;
    m_tready = 1'b1;
    foreach (tag_q[k]) mk_pkt(tag_q[k], 1, 0);
    c = 0;
    while (tag_q.size() > 0 && c < 60) begin
      drive_src(0);
      cycle();
      c++;
    end
    drive_src(0);
    cycle();
    n_tests++;
    if (o_pending !== '0) begin
      n_fail++;
      $display("FAIL drain_pending got %0d exp 0", o_pending);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_cmd_tvalid = 1'b0; s_cmd_ch = '0; s_cmd_tdata = {$urandom, $urandom, $urandom};
    m_cmd_tready = 1'b1; m_tready = 1'b1;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (pending !== 4'd0) begin n_fail++; $display("FAIL reset_pending got %0d exp 0", pending); end
    n_tests++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_m_tvalid got %b exp 0", m_tvalid); end
`ifdef S2H_STREAM_GATE_DRAIN_EN
    n_tests++; if (s_tready !== 2'b11) begin n_fail++; $display("FAIL reset_s_tready got %b exp 11", s_tready); end
`else
    n_tests++; if (s_tready !== 2'b00) begin n_fail++; $display("FAIL reset_s_tready got %b exp 00", s_tready); end
`endif
    n_tests++; if (pkt_done !== 1'b0) begin n_fail++; $display("FAIL reset_pkt_done got %b exp 0", pkt_done); end
    n_tests++; if (pkt_done_ch !== 1'b0) begin n_fail++; $display("FAIL reset_pkt_done_ch got %b exp 0", pkt_done_ch); end
    n_tests++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL reset_drop_count got %0d exp 0", drop_count); end
    n_tests++; if (m_cmd_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_m_cmd_tvalid got %b exp 0", m_cmd_tvalid); end
    n_tests++; if (m_cmd_tdata !== s_cmd_tdata) begin n_fail++; $display("FAIL cmd_passthru got %h exp %h", m_cmd_tdata, s_cmd_tdata); end
    @(posedge clk); #1;
    rst = 1'b0;
    tag_q.delete();
  endtask

  task automatic test_order();
    int   seen_done = 0;
    int   done_exp[$];
    beat_t b;
    exp_q.delete();
    mk_pkt(1, 3, 1);
    mk_pkt(0, 4, 1);
    done_exp.push_back(1);
    done_exp.push_back(0);
    m_tready = 1'b1; m_cmd_tready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c == 0) begin s_cmd_tvalid = 1'b1; s_cmd_ch = 1'b1; end
      else if (c == 1) s_cmd_ch = 1'b0;
      else s_cmd_tvalid = 1'b0;
      if (c >= 1) drive_src(0);
      cycle();
      if (c < 2) begin
        n_tests++; if (o_cmd_fire !== 1'b1) begin n_fail++; $display("FAIL order_cmd_fire c=%0d got %b exp 1", c, o_cmd_fire); end
      end
      if (c == 0) begin
        n_tests++; if (o_mvalid !== 1'b0) begin n_fail++; $display("FAIL order_no_same_cycle_start got %b exp 0", o_mvalid); end
      end
      if (o_done) begin
        n_tests++;
        if (done_exp.size() == 0 || int'(o_done_ch) != done_exp[0]) begin
          n_fail++; $display("FAIL order_done_ch got %0d", o_done_ch);
        end
        if (done_exp.size() > 0) void'(done_exp.pop_front());
        seen_done++;
      end
      if (o_sfire[0]) begin
        n_tests++; if (seen_done == 0) begin n_fail++; $display("FAIL order_ch0_early got fire exp stall"); end
      end
      if (o_mfire) begin
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL order_extra_beat got %h", o_data); end
        else begin
          b = exp_q.pop_front();
          if (o_data !== b.data || o_last !== b.last)
            begin n_fail++; $display("FAIL order_beat got %h/%b exp %h/%b", o_data, o_last, b.data, b.last); end
        end
      end
      if (seen_done == 2) break;
    end
    n_tests++; if (seen_done != 2) begin n_fail++; $display("FAIL order_done_count got %0d exp 2", seen_done); end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL order_left got %0d exp 0", exp_q.size()); end
    drive_src(0);
    cycle();
    n_tests++; if (o_pending !== '0) begin n_fail++; $display("FAIL order_pending got %0d exp 0", o_pending); end
  endtask

  task automatic test_toggle();
    int    fires = 0;
    bit    done = 0;
    beat_t b;
    exp_q.delete();
    mk_pkt(1, 5, 1);
    s_cmd_tvalid = 1'b1; s_cmd_ch = 1'b1; m_cmd_tready = 1'b1; m_tready = 1'b0;
    cycle();
    n_tests++; if (o_cmd_fire !== 1'b1) begin n_fail++; $display("FAIL toggle_cmd got %b exp 1", o_cmd_fire); end
    s_cmd_tvalid = 1'b0;
    for (int c = 0; c < 30; c++) begin
      m_tready = (c % 2 == 0);
      drive_src(0);
      cycle();
      if (fires < 5) begin
        n_tests++; if (o_mvalid !== 1'b1) begin n_fail++; $display("FAIL toggle_valid_held c=%0d got %b exp 1", c, o_mvalid); end
      end
      if (o_mfire) begin
        fires++;
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL toggle_dup_beat got %h", o_data); end
        else begin
          b = exp_q.pop_front();
          if (o_data !== b.data || o_last !== b.last)
            begin n_fail++; $display("FAIL toggle_beat got %h/%b exp %h/%b", o_data, o_last, b.data, b.last); end
        end
      end
      if (o_done) begin
        done = 1;
        n_tests++; if (o_done_ch !== 1'b1) begin n_fail++; $display("FAIL toggle_done_ch got %b exp 1", o_done_ch); end
        break;
      end
    end
    n_tests++; if (fires != 5) begin n_fail++; $display("FAIL toggle_fires got %0d exp 5", fires); end
    n_tests++; if (!done) begin n_fail++; $display("FAIL toggle_done got 0 exp 1"); end
  endtask

  task automatic test_push_pop();
    m_cmd_tready = 1'b1; m_tready = 1'b1; s_cmd_tvalid = 1'b1;
    s_cmd_ch = 1'b0; cycle();
    s_cmd_ch = 1'b1; cycle();
    s_cmd_ch = 1'b0; cycle();
    s_cmd_tvalid = 1'b0;
    cycle();
    n_tests++; if (o_pending !== 4'd3) begin n_fail++; $display("FAIL pp_pending3 got %0d exp 3", o_pending); end
    mk_pkt(0, 1, 0);
    mk_pkt(1, 1, 0);
    s_cmd_tvalid = 1'b1; s_cmd_ch = 1'b1;
    drive_src(0);
    cycle();
    n_tests++; if (o_cmd_fire !== 1'b1 || o_mfire !== 1'b1) begin n_fail++; $display("FAIL pp_both got cmd=%b data=%b exp 1/1", o_cmd_fire, o_mfire); end
    n_tests++; if (o_sready !== 2'b01) begin n_fail++; $display("FAIL pp_ready_before got %b exp 01", o_sready); end
    s_cmd_tvalid = 1'b0;
    drive_src(0);
    cycle();
    n_tests++; if (o_pending !== 4'd3) begin n_fail++; $display("FAIL pp_pending_kept got %0d exp 3", o_pending); end
    n_tests++; if (o_sready !== 2'b10) begin n_fail++; $display("FAIL pp_head_adv got %b exp 10", o_sready); end
    n_tests++; if (o_done !== 1'b1 || o_done_ch !== 1'b0) begin n_fail++; $display("FAIL pp_done got %b/%b exp 1/0", o_done, o_done_ch); end
    drain_fifo();
  endtask

  task automatic test_fill();
    int fires = 0;
    m_cmd_tready = 1'b1; m_tready = 1'b1; s_cmd_tvalid = 1'b1; s_cmd_ch = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (o_cmd_fire) fires++;
    end
    n_tests++; if (fires != 8) begin n_fail++; $display("FAIL fill_accepted got %0d exp 8", fires); end
    s_cmd_ch = 1'b1;
    cycle();
    n_tests++; if (o_pending !== 4'd8) begin n_fail++; $display("FAIL fill_pending got %0d exp 8", o_pending); end
    n_tests++; if (o_cmd_ready !== 1'b0 || o_mcv !== 1'b0) begin n_fail++; $display("FAIL fill_blocked got rdy=%b vld=%b exp 0/0", o_cmd_ready, o_mcv); end
    mk_pkt(0, 1, 0);
    drive_src(0);
    cycle();
    n_tests++; if (o_mfire !== 1'b1 || o_cmd_fire !== 1'b0) begin n_fail++; $display("FAIL fill_pop got data=%b cmd=%b exp 1/0", o_mfire, o_cmd_fire); end
    drive_src(0);
    cycle();
    n_tests++; if (o_cmd_fire !== 1'b1 || o_pending !== 4'd7) begin n_fail++; $display("FAIL fill_ninth got cmd=%b pend=%0d exp 1/7", o_cmd_fire, o_pending); end
    drain_fifo();
  endtask

  task automatic test_drain_mode();
    logic [15:0] d0;
    bit          moved = 0;
    d0 = drop_count;
    mk_pkt(0, 6, 0);
    m_tready = 1'b1; s_cmd_tvalid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      drive_src(0);
      cycle();
      if (o_mvalid) moved = 1;
`ifndef S2H_STREAM_GATE_DRAIN_EN
      if (o_sready[0] !== 1'b0 || o_sfire !== 2'b00) moved = 1;
`endif
    end
    n_tests++; if (moved) begin n_fail++; $display("FAIL drain_movement got 1 exp 0"); end
`ifdef S2H_STREAM_GATE_DRAIN_EN
    n_tests++; if (src_q[0].size() != 0) begin n_fail++; $display("FAIL drain_accepted got %0d left exp 0", src_q[0].size()); end
    n_tests++; if (drop_count !== d0 + 16'd6) begin n_fail++; $display("FAIL drain_count got %0d exp %0d", drop_count, d0 + 16'd6); end
`else
    n_tests++; if (src_q[0].size() != 6) begin n_fail++; $display("FAIL stall_left got %0d exp 6", src_q[0].size()); end
    n_tests++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL stall_count got %0d exp 0", drop_count); end
`endif
    src_q[0].delete();
    drive_src(0);
  endtask

  task automatic test_random();
    int          fired = 0;
    int          mdl_pending = 0;
    logic        exp_done = 1'b0;
    logic [CHW-1:0] exp_done_ch = '0;
    bit          finished = 0;
    beat_t       b;
    exp_q.delete();
    s_cmd_tvalid = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (fired < 40 && !s_cmd_tvalid) begin
        s_cmd_tvalid = 1'($urandom_range(1));
        s_cmd_ch = 1'($urandom_range(NUM_CH - 1));
        s_cmd_tdata = {$urandom, $urandom, $urandom};
      end
      m_cmd_tready = ($urandom_range(3) != 0);
      m_tready = ($urandom_range(3) != 0);
      drive_src(30);
      cycle();
      n_tests++; if (int'(o_pending) != mdl_pending) begin n_fail++; $display("FAIL rnd_pending c=%0d got %0d exp %0d", c, o_pending, mdl_pending); end
      n_tests++; if (o_cmd_ready !== (m_cmd_tready && mdl_pending < 8)) begin n_fail++; $display("FAIL rnd_cmd_ready c=%0d got %b", c, o_cmd_ready); end
      n_tests++; if (o_done !== exp_done || (exp_done && o_done_ch !== exp_done_ch))
        begin n_fail++; $display("FAIL rnd_done c=%0d got %b/%b exp %b/%b", c, o_done, o_done_ch, exp_done, exp_done_ch); end
      exp_done = 1'b0;
      if (o_mfire) begin
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL rnd_extra_beat got %h", o_data); end
        else begin
          b = exp_q.pop_front();
          if (o_data !== b.data || o_last !== b.last || o_sfire !== (2'b01 << b.ch))
            begin n_fail++; $display("FAIL rnd_beat got %h/%b/%b exp %h/%b ch%0d", o_data, o_last, o_sfire, b.data, b.last, b.ch); end
          if (o_last) begin
            exp_done = 1'b1;
            exp_done_ch = b.ch[CHW-1:0];
            mdl_pending--;
          end
        end
      end else begin
        n_tests++; if (o_sfire !== 2'b00) begin n_fail++; $display("FAIL rnd_stray_fire got %b exp 00", o_sfire); end
      end
      if (o_cmd_fire) begin
        fired++;
        mdl_pending++;
        mk_pkt(int'(s_cmd_ch), $urandom_range(4, 1), 1);
        s_cmd_tvalid = 1'b0;
      end
      if (fired == 40 && exp_q.size() == 0 && !exp_done && mdl_pending == 0) begin
        finished = 1;
        break;
      end
    end
    n_tests++; if (!finished) begin n_fail++; $display("FAIL rnd_timeout fired=%0d left=%0d", fired, exp_q.size()); end
    s_cmd_tvalid = 1'b0;
  endtask

  task automatic test_reset_mid();
    m_cmd_tready = 1'b1; m_tready = 1'b1;
    s_cmd_tvalid = 1'b1; s_cmd_ch = 1'b0;
    cycle();
    s_cmd_tvalid = 1'b0;
    mk_pkt(0, 4, 0);
    drive_src(0);
    cycle();
    n_tests++; if (o_mfire !== 1'b1) begin n_fail++; $display("FAIL rstmid_beat1 got %b exp 1", o_mfire); end
    rst = 1'b1;
    drive_src(0);
    cycle();
    n_tests++; if (o_mfire !== 1'b1) begin n_fail++; $display("FAIL rstmid_beat2 got %b exp 1", o_mfire); end
    rst = 1'b0;
    drive_src(0);
    cycle();
    n_tests++; if (o_pending !== '0) begin n_fail++; $display("FAIL rstmid_pending got %0d exp 0", o_pending); end
    n_tests++; if (o_mvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_m_tvalid got %b exp 0", o_mvalid); end
`ifdef S2H_STREAM_GATE_DRAIN_EN
    n_tests++; if (o_sready !== 2'b11) begin n_fail++; $display("FAIL rstmid_s_tready got %b exp 11", o_sready); end
`else
    n_tests++; if (o_sready !== 2'b00) begin n_fail++; $display("FAIL rstmid_s_tready got %b exp 00", o_sready); end
`endif
    src_q[0].delete();
    drive_src(0);
  endtask

  initial begin
    test_reset();
    test_order();
    test_toggle();
    test_push_pop();
    test_fill();
    test_drain_mode();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/s2h_stream_gate.md
# s2h_stream_gate

Command-ordered gate and multiplexer between NUM_CH custom-hardware output streams and the single S2MM stream input of the AXI datamover. Every S2MM command accepted by the datamover pushes its channel tag into a small tag FIFO. The gate then passes exactly one packet, ending on tlast, from the channel at the FIFO head. This generalises the single-bit "active between command and tlast" workaround to multiple outstanding commands and multiple source channels.

## Interface
- NUM_CH, default 2: number of source streams, 1..16.
- DATA_W, default 64: stream data width.
- CMD_W, default 72: datamover command width (passed through unmodified).
- DEPTH_LOG2, default 3: the tag FIFO holds 2^DEPTH_LOG2 outstanding commands.
- Derived constant CH_W = max(1, clog2(NUM_CH)).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- s_cmd_tvalid  in  1  command from the control master.
- s_cmd_tready  out  1  ready to the control master.
- s_cmd_tdata  in  CMD_W  command payload.
- s_cmd_ch  in  CH_W  channel tag qualified with s_cmd_tvalid.
- m_cmd_tvalid  out  1  command to the datamover.
- m_cmd_tready  in  1  datamover command ready.
- m_cmd_tdata  out  CMD_W  equals s_cmd_tdata.
- s_tdata  in  NUM_CH*DATA_W  source data; channel i occupies bits [i*DATA_W +: DATA_W].
- s_tvalid  in  NUM_CH  per-channel valid.
- s_tlast  in  NUM_CH  per-channel last.
- s_tready  out  NUM_CH  per-channel ready.
- m_tdata  out  DATA_W  to datamover S2MM.
- m_tvalid  out  1  to datamover S2MM.
- m_tlast  out  1  to datamover S2MM.
- m_tready  in  1  from datamover S2MM.
- pending  out  DEPTH_LOG2+1  outstanding command count.
- pkt_done  out  1  one-cycle pulse when a packet completes.
- pkt_done_ch  out  CH_W  channel of the completed packet; valid with pkt_done.
- drop_count  out  16  discarded-beat counter; tied to 0 when drain mode is not compiled in.

## Operation
- Command path:
  - full = (pending == 2^DEPTH_LOG2).
  - m_cmd_tvalid = s_cmd_tvalid & !full.
  - s_cmd_tready = m_cmd_tready & !full.
  - A push happens on cmd_fire = m_cmd_tvalid & m_cmd_tready, writing s_cmd_ch to the tag FIFO.
  - A tag with value ≥ NUM_CH is pushed as-is. Its packet never arrives; the head stalls until reset.
- Gate state is one of two states:
  - IDLE: FIFO empty.
  - OPEN: FIFO non-empty; head = tag at the read pointer.
- In OPEN:
  - m_tdata, m_tvalid and m_tlast are taken from channel head.
  - s_tready[head] = m_tready; all other s_tready are 0.
- In IDLE: m_tvalid = 0, and s_tready = 0 for all channels unless drain mode is compiled in.
- A pop happens on data_fire = m_tvalid & m_tready & m_tlast. On the next clock:
  - pkt_done = 1.
  - pkt_done_ch = the popped tag.
- pending update:
  - push only: +1.
  - pop only: −1.
  - push and pop in the same cycle: unchanged; both pointers advance.
- Pointers wrap modulo 2^DEPTH_LOG2.
- Packet boundaries are tlast only; beat count is not checked.

## Timing
- Reset values: pending = 0; FIFO pointers = 0; m_tvalid = 0; s_tready = 0; pkt_done = 0; pkt_done_ch = 0; drop_count = 0. m_cmd_tvalid and s_cmd_tready are combinational and are 0 whenever full.
- A pushed tag becomes visible at the head the cycle after cmd_fire. A packet therefore cannot start in the same cycle as its command.
- Data path is zero-latency combinational, from the head register through the mux to the outputs. There is no data storage.
- After a pop, the next head (if any) is active in the following cycle. There are no bubbles beyond that one-cycle head update.
- m_tvalid must not drop while m_tready is low unless the source drops s_tvalid. The gate itself never changes head mid-packet.
- Full: command accepted only after a pop. Pop and push in the same cycle as full is reached are both legal.
- Reset mid-packet clears the FIFO and closes the gate immediately. The partially sent packet is abandoned; datamover recovery is the software's responsibility.

## Configuration
- S2H_STREAM_GATE_DRAIN_EN defined:
  - In IDLE, all s_tready = 1. Any valid beat is discarded and drop_count increments, saturating at 16'hFFFF.
  - In OPEN, non-head channels still stall.
- Not defined: stray beats stall in IDLE, and drop_count is constant 0.

## Structure
- Package s2h_gate_pkg holds:
  - gate_state_t (IDLE, OPEN).
  - A ch_idx function computing CH_W.
  - DROP_CNT_W = 16.
- Sub-module s2h_tag_fifo: a synchronous FIFO of width CH_W and depth 2^DEPTH_LOG2 with a count output. It is instantiated once.
- The top level holds the gate, mux, pulse and drop logic.

## Test plan
- NUM_CH=2: push cmd ch1, then ch0; ch0 offers 4 beats first, ch1 offers 3 beats ending in tlast → ch1's 3 beats emerge first, ch0 is stalled until pkt_done with pkt_done_ch=1, then ch0's 4 beats pass; final pending=0.
- Fill: push 8 commands with DEPTH_LOG2=3 → pending=8, s_cmd_tready=0; one packet completes → 9th command accepted the next cycle.
- Push and pop in the same cycle with pending=3 → pending stays 3, and the head advances to the next tag.
- m_tready toggling 1,0,1,0 during a 5-beat packet → exactly 5 data_fires, data order preserved, no beat duplicated.
- Drain mode: pending=0 and ch0 sends 6 beats → all accepted and drop_count=6. Without the macro → s_tready[0]=0 and no movement.
- rst asserted on beat 2 of 4 → next cycle pending=0, m_tvalid=0, all s_tready=0 (no drain).
